ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports rd1_ex and rd2_ex, input, WIDTH: register operands.
REQ-005 SHALL have ports pcinc_ex and extended_d_ex, input, WIDTH: PC+1 and extended immediate.
REQ-006 SHALL have port d_ex, input, 4: raw shift amount.
REQ-007 SHALL have ports fwd_mem_dat and fwd_wb_dat, input, WIDTH: forwarded results.
REQ-008 SHALL have ports ALUsrcA_controll and ALUsrcB_controll, input, 3 each: operand selects.
REQ-009 SHALL have port ALUop, input, 4: operation code.
REQ-010 SHALL have ports setflag_ex and kill_ex, input, 1 each: flag-write enable and abort.
REQ-011 SHALL have port alu_result, output, WIDTH: EX result.
REQ-012 SHALL have port flags, output, 4: registered {S,Z,C,V}.
REQ-013 SHALL have port ex_stall, output, 1: holds IF/ID/ID-EX while high.

Function
REQ-014 SHALL select A as: 0 rd1_ex, 1 fwd_mem_dat, 2 fwd_wb_dat, 3 pcinc_ex, others zero.
REQ-015 SHALL select B as: 0 rd2_ex, 1 fwd_mem_dat, 2 fwd_wb_dat, 3 extended_d_ex, 4 zero-extended d_ex, others zero.
REQ-016 SHALL decode ALUop as: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 CMP (=SUB), 6 MOV (B), 7 SLL, 8 SLR (rotate left), 9 SRL, 10 SRA, 11 MUL, 12-15 reserved.
REQ-017 SHALL produce single-cycle ops combinationally, result modulo 2^WIDTH.
REQ-018 SHALL take shift amount from B[3:0]; amount 0 gives A with C=0.
REQ-019 SHALL compute flags as: S=result[MSB], Z=(result==0); ADD C=carry-out; SUB/CMP C=borrow (A<B unsigned); V=signed overflow for ADD/SUB/CMP; shifts C=last bit out, V=0; logic/MOV/MUL C=V=0.
REQ-020 SHALL give reserved ops result 0, flags {0,1,0,0}, no stall.
REQ-021 SHALL latch flags at the edge only when setflag_ex=1 and ex_stall=0.
REQ-022 SHALL run MUL as FSM IDLE->RUN->DONE->IDLE, serial shift-add, one multiplier bit per cycle, low WIDTH product bits kept.
REQ-023 SHALL, in IDLE with ALUop=MUL, raise ex_stall combinationally, latch A/B, clear the accumulator and counter, and go to RUN.
REQ-024 SHALL hold RUN exactly WIDTH cycles with ex_stall=1, then enter DONE.
REQ-025 SHALL, in DONE, drive ex_stall=0 and alu_result=product, then return to IDLE unconditionally.
REQ-026 SHALL give MUL ex_stall=1 for exactly WIDTH+1 consecutive cycles; the result is valid in the next cycle.
REQ-027 SHALL, on kill_ex=1 in any state, go to IDLE next edge, drop ex_stall that cycle, and not update flags.
REQ-028 SHALL not restart MUL in DONE even though ALUop still reads MUL.

Reset
REQ-029 SHALL, while reset=0, force flags=0, FSM=IDLE, counter=0, operand/accumulator=0, ex_stall=0.
REQ-030 SHALL abort a reset asserted mid-MUL with no partial result retained.

Configuration
REQ-031 SHALL build serial MUL (REQ-022..028) only when EX_MUL_EN is defined.
REQ-032 SHALL, without EX_MUL_EN, treat ALUop 11 as reserved (REQ-020), omit the FSM, and tie ex_stall low.

Structure
REQ-033 SHALL place the ALUop encodings, srcA/srcB selects, flag bit indices and MUL state enum in shared package alu_pkg.
REQ-034 SHALL implement the serial multiplier as sub-module mul_serial (start, kill, busy, done, product).

Verification
REQ-035 SHALL cover: ADD A=16'h7FFF, B=16'h0001, setflag=1 -> result 16'h8000, flags S=1,Z=0,C=0,V=1.
REQ-036 SHALL cover: SUB/CMP A=3, B=5 -> result 16'hFFFE, C=1, S=1; with setflag=0 flags unchanged.
REQ-037 SHALL cover: SRA A=16'h8001, d_ex=1, srcB=4 -> 16'hC000, C=1; amount 0 -> 16'h8001, C=0.
REQ-038 SHALL cover: MUL 16'h0123 x 16'h0045 -> ex_stall high 17 cycles, then result 16'h4E6F for one cycle, FSM back in IDLE.
REQ-039 SHALL cover: kill_ex at RUN cycle 5 -> ex_stall low next cycle, flags unchanged; a following MUL completes correctly.
REQ-040 SHALL cover: reset low mid-MUL -> flags=0, ex_stall=0 immediately; build without EX_MUL_EN -> ALUop 11 gives 0, no stall.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared EX-stage encodings: ALU opcodes, operand selects, flag bit positions and MUL FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOr  = 4'd3,
    OpXor = 4'd4,
    OpCmp = 4'd5,
    OpMov = 4'd6,
    OpSll = 4'd7,
    OpSlr = 4'd8,
    OpSrl = 4'd9,
    OpSra = 4'd10,
    OpMul = 4'd11
  } alu_op_e;

  localparam logic [2:0] SrcARd1    = 3'd0;
  localparam logic [2:0] SrcAFwdMem = 3'd1;
  localparam logic [2:0] SrcAFwdWb  = 3'd2;
  localparam logic [2:0] SrcAPcInc  = 3'd3;

  localparam logic [2:0] SrcBRd2    = 3'd0;
  localparam logic [2:0] SrcBFwdMem = 3'd1;
  localparam logic [2:0] SrcBFwdWb  = 3'd2;
  localparam logic [2:0] SrcBExtImm = 3'd3;
  localparam logic [2:0] SrcBShAmt  = 3'd4;

  localparam int unsigned FlagS = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {
    MulIdle = 2'd0,
    MulRun  = 2'd1,
    MulDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_serial.sv
// Serial shift-add multiplier: one multiplier bit per cycle, keeps the low WIDTH product bits.
module mul_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mul_state_e       r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a;
  logic [WIDTH-1:0] r_b, w_b;
  logic [WIDTH-1:0] r_acc, w_acc;
  logic [CntW-1:0]  r_cnt, w_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= MulIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_acc   <= w_acc;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_acc   = r_acc;
    w_cnt   = r_cnt;
    busy    = 1'b0;
    done    = 1'b0;
    // Kill (and reset) drop busy in the same cycle so the pipeline is released at once.
    if (!reset || kill) begin
      w_state = MulIdle;
    end else begin
      unique case (r_state)
        MulIdle: begin
          if (start) begin
            busy    = 1'b1;
            w_state = MulRun;
            w_a     = a;
            w_b     = b;
            w_acc   = '0;
            w_cnt   = '0;
          end
        end
        MulRun: begin
          busy = 1'b1;
          if (r_b[0]) w_acc = r_acc + r_a;
          w_a   = r_a << 1;
          w_b   = r_b >> 1;
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == CntW'(WIDTH - 1)) w_state = MulDone;
        end
        MulDone: begin
          done    = 1'b1;
          w_state = MulIdle;
        end
        default: w_state = MulIdle;
      endcase
    end
  end

  assign product = r_acc;

endmodule

// File: rtl/ex_stage.sv
// EX stage: operand muxes, single-cycle ALU, registered {S,Z,C,V} flags.
// Define EX_MUL_EN to build the stalling serial MUL; otherwise ALUop MUL is reserved.
module ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd1_ex,
  input  logic [WIDTH-1:0] rd2_ex,
  input  logic [WIDTH-1:0] pcinc_ex,
  input  logic [WIDTH-1:0] extended_d_ex,
  input  logic [3:0]       d_ex,
  input  logic [WIDTH-1:0] fwd_mem_dat,
  input  logic [WIDTH-1:0] fwd_wb_dat,
  input  logic [2:0]       ALUsrcA_controll,
  input  logic [2:0]       ALUsrcB_controll,
  input  logic [3:0]       ALUop,
  input  logic             setflag_ex,
  input  logic             kill_ex,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       flags,
  output logic             ex_stall
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_op_e           w_op;
  logic [WIDTH-1:0]  w_a, w_b, w_res, w_rol;
  logic [WIDTH:0]    w_sum, w_diff, w_sll, w_srl;
  logic signed [WIDTH:0] w_sra;
  logic [3:0]        w_amt, w_flags, r_flags;
  logic              w_c, w_v;

  assign w_op = alu_op_e'(ALUop);

  always_comb begin
    case (ALUsrcA_controll)
      SrcARd1:    w_a = rd1_ex;
      SrcAFwdMem: w_a = fwd_mem_dat;
      SrcAFwdWb:  w_a = fwd_wb_dat;
      SrcAPcInc:  w_a = pcinc_ex;
      default:    w_a = '0;
    endcase
    case (ALUsrcB_controll)
      SrcBRd2:    w_b = rd2_ex;
      SrcBFwdMem: w_b = fwd_mem_dat;
      SrcBFwdWb:  w_b = fwd_wb_dat;
      SrcBExtImm: w_b = extended_d_ex;
      SrcBShAmt:  w_b = {{(WIDTH-4){1'b0}}, d_ex};
      default:    w_b = '0;
    endcase
  end

  // Extra bit on each shifter catches the last bit shifted out as carry.
  assign w_amt  = w_b[3:0];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_sll  = {1'b0, w_a} << w_amt;
  assign w_srl  = {w_a, 1'b0} >> w_amt;
  assign w_sra  = $signed({w_a, 1'b0}) >>> w_amt;
  assign w_rol  = (w_a << w_amt) | (w_a >> (WIDTH - 32'(w_amt)));

`ifdef EX_MUL_EN
  logic             w_mul_busy, w_mul_done;
  logic [WIDTH-1:0] w_mul_prod;

  mul_serial #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_op == OpMul),
    .kill    (kill_ex),
    .a       (w_a),
    .b       (w_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );

  assign ex_stall = w_mul_busy;
`else
  assign ex_stall = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OpAdd: begin
        {w_c, w_res} = w_sum;
        w_v = (w_a[Msb] == w_b[Msb]) && (w_sum[Msb] != w_a[Msb]);
      end
      OpSub, OpCmp: begin
        {w_c, w_res} = w_diff;
        w_v = (w_a[Msb] != w_b[Msb]) && (w_diff[Msb] != w_a[Msb]);
      end
      OpAnd: w_res = w_a & w_b;
      OpOr:  w_res = w_a | w_b;
      OpXor: w_res = w_a ^ w_b;
      OpMov: w_res = w_b;
      OpSll: {w_c, w_res} = w_sll;
      OpSlr: begin
        w_res = w_rol;
        w_c   = (w_amt != 4'd0) && w_rol[0];
      end
      OpSrl: {w_res, w_c} = w_srl;
      OpSra: {w_res, w_c} = w_sra;
`ifdef EX_MUL_EN
      OpMul: w_res = w_mul_done ? w_mul_prod : '0;
`endif
      default: w_res = '0;
    endcase
    w_flags        = '0;
    w_flags[FlagS] = w_res[Msb];
    w_flags[FlagZ] = (w_res == '0);
    w_flags[FlagC] = w_c;
    w_flags[FlagV] = w_v;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (setflag_ex && !ex_stall && !kill_ex) begin
      r_flags <= w_flags;
    end
  end

  assign alu_result = w_res;
  assign flags      = r_flags;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: random and directed ops checked against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_ex_stage;

  localparam int unsigned W = 16;
`ifdef EX_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] rd1_ex, rd2_ex, pcinc_ex, extended_d_ex, fwd_mem_dat, fwd_wb_dat;
  logic [3:0]   d_ex, ALUop;
  logic [2:0]   ALUsrcA_controll, ALUsrcB_controll;
  logic         setflag_ex, kill_ex;
  logic [W-1:0] alu_result;
  logic [3:0]   flags;
  logic         ex_stall;

  ex_stage #(.WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .rd1_ex           (rd1_ex),
    .rd2_ex           (rd2_ex),
    .pcinc_ex         (pcinc_ex),
    .extended_d_ex    (extended_d_ex),
    .d_ex             (d_ex),
    .fwd_mem_dat      (fwd_mem_dat),
    .fwd_wb_dat       (fwd_wb_dat),
    .ALUsrcA_controll (ALUsrcA_controll),
    .ALUsrcB_controll (ALUsrcB_controll),
    .ALUop            (ALUop),
    .setflag_ex       (setflag_ex),
    .kill_ex          (kill_ex),
    .alu_result       (alu_result),
    .flags            (flags),
    .ex_stall         (ex_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    bit           chk_res;
    logic [3:0]   flg;
    int           stalls;
    int           id;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         checks = 0;
  int         errors = 0;
  int         item_id = 0;
  int         mon_stalls = 0;
  bit         mon_en = 1'b0;
  logic [3:0] mflags = 4'b0000;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] sel_a(input logic [2:0] s);
    case (s)
      3'd0:    return rd1_ex;
      3'd1:    return fwd_mem_dat;
      3'd2:    return fwd_wb_dat;
      3'd3:    return pcinc_ex;
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] sel_b(input logic [2:0] s);
    case (s)
      3'd0:    return rd2_ex;
      3'd1:    return fwd_mem_dat;
      3'd2:    return fwd_wb_dat;
      3'd3:    return extended_d_ex;
      3'd4:    return {{(W-4){1'b0}}, d_ex};
      default: return '0;
    endcase
  endfunction

  // Reference: integer arithmetic for add/sub/mul, bit-at-a-time loops for shifts.
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] res,
                                output logic [3:0] flg);
    longint ua, ub, sa, sb, full, two_w, smax, smin;
    logic [W-1:0] x;
    bit c, v;
    int amt;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    two_w = longint'(1) << W;
    smax = two_w / 2 - 1;
    smin = -(two_w / 2);
    c = 1'b0;
    v = 1'b0;
    x = a;
    amt = int'(b[3:0]);
    res = '0;
    case (op)
      4'd0: begin
        full = ua + ub;
        res = W'(full);
        c = (full >= two_w);
        v = (sa + sb > smax) || (sa + sb < smin);
      end
      4'd1, 4'd5: begin
        res = W'(ua - ub);
        c = (ua < ub);
        v = (sa - sb > smax) || (sa - sb < smin);
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd6: res = b;
      4'd7: begin
        for (int i = 0; i < amt; i++) begin c = x[W-1]; x = {x[W-2:0], 1'b0}; end
        res = x;
      end
      4'd8: begin
        for (int i = 0; i < amt; i++) begin c = x[W-1]; x = {x[W-2:0], x[W-1]}; end
        res = x;
      end
      4'd9: begin
        for (int i = 0; i < amt; i++) begin c = x[0]; x = {1'b0, x[W-1:1]}; end
        res = x;
      end
      4'd10: begin
        for (int i = 0; i < amt; i++) begin c = x[0]; x = {x[W-1], x[W-1:1]}; end
        res = x;
      end
      4'd11: res = MulEn ? W'(ua * ub) : '0;
      default: res = '0;
    endcase
    flg = {res[W-1], (res == '0), c, v};
  endfunction

  // Drive one instruction, queue its expectation, hold it until the stage accepts it.
  task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic sf, input int kill_at);
    logic [W-1:0] res;
    logic [3:0]   flg;
    exp_t         e;
    bit           is_mul, killed;
    int           n;
    ALUop = op;
    ALUsrcA_controll = sa;
    ALUsrcB_controll = sb;
    setflag_ex = sf;
    kill_ex = 1'b0;
    model(op, sel_a(sa), sel_b(sb), res, flg);
    is_mul = MulEn && (op == 4'd11);
    killed = is_mul && (kill_at > 0);
    e.res = res;
    e.chk_res = !killed;
    e.flg = mflags;
    e.stalls = killed ? kill_at : (is_mul ? W + 1 : 0);
    e.id = item_id++;
    q.push_back(e);
    if (sf && !killed) mflags = flg;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!ex_stall) break;
      n++;
      if (n > 3 * W) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout item %0d: stalled %0d cycles, expected at most %0d",
                 e.id, n, W + 1);
        break;
      end
      @(posedge clk);
      #1;
      if (n == kill_at) kill_ex = 1'b1;
    end
    @(posedge clk);
    #1;
    kill_ex = 1'b0;
  endtask

  // Monitor: a non-stalled cycle is the stage presenting its result.
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en || !reset) begin
        mon_stalls = 0;
      end else if (ex_stall) begin
        mon_stalls++;
      end else if (q.size() != 0) begin
        m_e = q.pop_front();
        if (m_e.chk_res) begin
          checks++;
          if (alu_result !== m_e.res) begin
            errors++;
            $display("FAIL result item %0d: got %h, expected %h", m_e.id, alu_result, m_e.res);
          end
        end
        checks++;
        if (flags !== m_e.flg) begin
          errors++;
          $display("FAIL flags item %0d: got %b, expected %b", m_e.id, flags, m_e.flg);
        end
        checks++;
        if (mon_stalls != m_e.stalls) begin
          errors++;
          $display("FAIL stall_len item %0d: got %0d, expected %0d", m_e.id, mon_stalls,
                   m_e.stalls);
        end
        mon_stalls = 0;
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] op;
    rd1_ex = '0; rd2_ex = '0; pcinc_ex = '0; extended_d_ex = '0; d_ex = '0;
    fwd_mem_dat = '0; fwd_wb_dat = '0; ALUsrcA_controll = '0; ALUsrcB_controll = '0;
    ALUop = '0; setflag_ex = 1'b0; kill_ex = 1'b0;
    #1;
    check_eq("reset_flags", 32'(flags), 32'h0);
    check_eq("reset_stall", 32'(ex_stall), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // ADD signed overflow
    rd1_ex = 16'h7FFF; rd2_ex = 16'h0001;
    issue(4'd0, 3'd0, 3'd0, 1'b1, -1);
    check_eq("add_flags", 32'(flags), 32'b1001);
    // SUB 3-5 borrows; CMP with setflag=0 leaves flags
    rd1_ex = 16'd3; rd2_ex = 16'd5;
    issue(4'd1, 3'd0, 3'd0, 1'b1, -1);
    check_eq("sub_flags", 32'(flags), 32'b1010);
    rd1_ex = 16'd0; rd2_ex = 16'd0;
    issue(4'd5, 3'd0, 3'd0, 1'b0, -1);
    check_eq("cmp_noset_flags", 32'(flags), 32'b1010);
    // SRA by 1 and by 0 via zero-extended d_ex
    rd1_ex = 16'h8001; d_ex = 4'd1;
    issue(4'd10, 3'd0, 3'd4, 1'b1, -1);
    d_ex = 4'd0;
    issue(4'd10, 3'd0, 3'd4, 1'b1, -1);
    check_eq("sra0_flags", 32'(flags), 32'b1000);
    // MUL 0x0123 * 0x0045
    rd1_ex = 16'h0123; rd2_ex = 16'h0045;
    issue(4'd11, 3'd0, 3'd0, 1'b1, -1);
    check_eq("mul_flags", 32'(flags), MulEn ? 32'b0000 : 32'b0100);
    // Kill a MUL in its fifth stall cycle; flags must stay as the ADD left them
    rd1_ex = 16'h7FFF; rd2_ex = 16'h0001;
    issue(4'd0, 3'd0, 3'd0, 1'b1, -1);
    rd1_ex = 16'h1234; rd2_ex = 16'h0FF1;
    issue(4'd11, 3'd0, 3'd0, 1'b1, 5);
    check_eq("kill_flags", 32'(flags), MulEn ? 32'b1001 : 32'b0100);
    rd1_ex = 16'h0123; rd2_ex = 16'h0045;
    issue(4'd11, 3'd0, 3'd0, 1'b0, -1);
    // Reserved opcode
    issue(4'd13, 3'd0, 3'd0, 1'b1, -1);
    check_eq("reserved_flags", 32'(flags), 32'b0100);

    for (int i = 0; i < 300; i++) begin
      rd1_ex = pick(); rd2_ex = pick(); pcinc_ex = pick(); extended_d_ex = pick();
      fwd_mem_dat = pick(); fwd_wb_dat = pick(); d_ex = 4'($urandom);
      op = 4'($urandom_range(0, 15));
      if (op == 4'd11 && $urandom_range(0, 2) != 0) op = 4'd0;
      issue(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), -1);
    end

    // Reset asserted mid-MUL: everything clears at once, next MUL is clean
    rd1_ex = 16'h7FFF; rd2_ex = 16'h0001;
    issue(4'd0, 3'd0, 3'd0, 1'b1, -1);
    mon_en = 1'b0;
    rd1_ex = 16'hABCD; rd2_ex = 16'h0077;
    ALUop = 4'd11; ALUsrcA_controll = 3'd0; ALUsrcB_controll = 3'd0; setflag_ex = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("midmul_reset_flags", 32'(flags), 32'h0);
    check_eq("midmul_reset_stall", 32'(ex_stall), 32'h0);
    ALUop = 4'd0; setflag_ex = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    mflags = 4'b0000;
    mon_en = 1'b1;
    rd1_ex = 16'h0123; rd2_ex = 16'h0045;
    issue(4'd11, 3'd0, 3'd0, 1'b1, -1);
    rd1_ex = 16'hFFFF; rd2_ex = 16'hFFFF;
    issue(4'd11, 3'd0, 3'd0, 1'b1, -1);

    repeat (2) @(posedge clk);
    #1;
    check_eq("queue_drained", 32'(q.size()), 32'h0);
    check_eq("final_flags", 32'(flags), 32'(mflags));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
